// File: rtl/neuron_accumulator_if.sv
// Handshake bundle between a product source, the neuron accumulator and its result consumer.
// master = upstream/downstream environment, slave = accumulator.
interface neuron_accumulator_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_product;
    logic [31:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  beat_count;

    modport master (
        output in_valid, in_product, bias, out_ready,
        input  in_ready, out_valid, out_data, beat_count
    );

    modport slave (
        input  in_valid, in_product, bias, out_ready,
        output in_ready, out_valid, out_data, beat_count
    );
endinterface

// File: rtl/neuron_accumulator.sv
// Sums NUM_INPUTS signed products plus a bias in a 40-bit accumulator, then presents one
// saturated (optionally ReLU-clipped) 32-bit result with valid/ready backpressure.
module neuron_accumulator #(
    parameter int NUM_INPUTS = 4,
    parameter int RELU       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    neuron_accumulator_if.slave  bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [7:0]         LAST_BEAT = 8'(NUM_INPUTS - 1);
    localparam logic signed [39:0] SAT_MAX   = 40'sh007FFFFFFF;
    localparam logic signed [39:0] SAT_MIN   = 40'shFF80000000;

    state_t             state_q, state_d;
    logic signed [39:0] acc_q, acc_d;
    logic [7:0]         beat_q, beat_d;
    logic [31:0]        out_q, out_d;

    logic               accept;
    logic signed [39:0] base;
    logic signed [39:0] sum;
    logic [31:0]        sat;
    logic [31:0]        result;

    assign accept = bus.in_valid && (state_q == ACCUM);

    // First beat of a group starts from the bias instead of the stale accumulator.
    assign base = (beat_q == 8'd0) ? {{8{bus.bias[31]}}, bus.bias} : acc_q;
    assign sum  = base + {{8{bus.in_product[31]}}, bus.in_product};

    always_comb begin
        sat = sum[31:0];
        if (sum > SAT_MAX) begin
            sat = 32'h7FFF_FFFF;
        end else if (sum < SAT_MIN) begin
            sat = 32'h8000_0000;
        end
        result = ((RELU != 0) && sat[31]) ? 32'h0000_0000 : sat;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        out_d   = out_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d  = sum;
                    beat_d = 8'(beat_q + 8'd1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = HOLD;
                        out_d   = result;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                    beat_d  = 8'd0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            beat_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            out_q   <= out_d;
        end
    end

    assign bus.in_ready   = (state_q == ACCUM);
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_data   = out_q;
    assign bus.beat_count = beat_q;
endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: one ReLU and one pass-through instance share stimulus;
// expected results go into queues that a negedge monitor pops on each output handshake.
module tb_neuron_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_product = '0;
    logic [31:0] bias = '0;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } probe_t;

    probe_t      probe_q[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q0[$];

    always #5 clk = ~clk;

    neuron_accumulator_if if_r1 ();
    neuron_accumulator_if if_r0 ();

    assign if_r1.in_valid   = in_valid;
    assign if_r1.in_product = in_product;
    assign if_r1.bias       = bias;
    assign if_r1.out_ready  = out_ready;
    assign if_r0.in_valid   = in_valid;
    assign if_r0.in_product = in_product;
    assign if_r0.bias       = bias;
    assign if_r0.out_ready  = out_ready;

    neuron_accumulator #(.NUM_INPUTS(4), .RELU(1)) u_relu (.clk(clk), .rst(rst), .bus(if_r1));
    neuron_accumulator #(.NUM_INPUTS(4), .RELU(0)) u_pass (.clk(clk), .rst(rst), .bus(if_r0));

    // Single monitor: owns all counters, compares probes and scoreboard entries.
    always @(negedge clk) begin
        while (probe_q.size() > 0) begin
            probe_t pr;
            pr = probe_q.pop_front();
            checks++;
            if (pr.act !== pr.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", pr.name, pr.act, pr.exp);
            end
        end
        if (!rst && if_r1.out_valid) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL relu_out: unexpected result 0x%08h, nothing expected", if_r1.out_data);
            end else if (if_r1.out_data !== exp_q1[0]) begin
                errors++;
                $display("FAIL relu_out: got 0x%08h expected 0x%08h", if_r1.out_data, exp_q1[0]);
            end else begin
                $display("relu result 0x%08h ok (out_ready=%0b)", if_r1.out_data, out_ready);
            end
            checks++;
            if (if_r1.in_ready !== 1'b0 || if_r1.beat_count !== 8'd4) begin
                errors++;
                $display("FAIL relu_hold: in_ready=%0b beat_count=%0d expected 0 and 4",
                         if_r1.in_ready, if_r1.beat_count);
            end
            if (out_ready && exp_q1.size() > 0) void'(exp_q1.pop_front());
        end
        if (!rst && if_r0.out_valid) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL pass_out: unexpected result 0x%08h, nothing expected", if_r0.out_data);
            end else if (if_r0.out_data !== exp_q0[0]) begin
                errors++;
                $display("FAIL pass_out: got 0x%08h expected 0x%08h", if_r0.out_data, exp_q0[0]);
            end else begin
                $display("pass result 0x%08h ok (out_ready=%0b)", if_r0.out_data, out_ready);
            end
            if (out_ready && exp_q0.size() > 0) void'(exp_q0.pop_front());
        end
    end

    task automatic probe(input string name, input logic [31:0] act, input logic [31:0] exp);
        probe_t pr;
        pr.name = name;
        pr.act  = act;
        pr.exp  = exp;
        probe_q.push_back(pr);
    endtask

    task automatic send_beat(input logic [31:0] p, input logic [31:0] b);
        int t = 0;
        in_valid   = 1'b1;
        in_product = p;
        bias       = b;
        @(negedge clk);
        while (!if_r1.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) probe("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Later beats carry an inverted bias so a design that re-samples bias gets caught.
    task automatic send_group(input logic [31:0] b,
                              input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3,
                              input int gap_max,
                              input logic [31:0] e_relu, input logic [31:0] e_pass);
        exp_q1.push_back(e_relu);
        exp_q0.push_back(e_pass);
        send_beat(p0, b);
        repeat ($urandom_range(gap_max, 0)) @(posedge clk);
        #1;
        send_beat(p1, ~b);
        repeat ($urandom_range(gap_max, 0)) @(posedge clk);
        #1;
        send_beat(p2, ~b);
        repeat ($urandom_range(gap_max, 0)) @(posedge clk);
        #1;
        send_beat(p3, ~b);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        probe("reset_in_ready",   {31'd0, if_r1.in_ready},  32'd1);
        probe("reset_out_valid",  {31'd0, if_r1.out_valid}, 32'd0);
        probe("reset_beat_count", {24'd0, if_r1.beat_count}, 32'd0);
        probe("reset_out_data",   if_r0.out_data, 32'd0);

        // Basic sum, consecutive beats, and one-cycle latency to out_valid.
        send_group(32'd10, 32'd1, 32'd2, 32'd3, 32'd4, 0, 32'd20, 32'd20);
        probe("latency_out_valid", {31'd0, if_r1.out_valid}, 32'd1);
        probe("final_beat_count",  {24'd0, if_r1.beat_count}, 32'd4);

        send_group(32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0,
                   32'h7FFFFFFF, 32'h7FFFFFFF);
        send_group(32'd0, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 0,
                   32'h00000000, 32'h80000000);
        send_group(32'd3, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd0, 32'd0, 0,
                   32'h00000000, 32'hFFFFFFF9);
        send_group(32'hFFFFFF9C, 32'd50, 32'd20, 32'd10, 32'd5, 0,
                   32'h00000000, 32'hFFFFFFF1);
        send_group(32'h7FFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 0,
                   32'h7FFFFFFF, 32'h7FFFFFFF);
        send_group(32'h80000000, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 0,
                   32'h00000000, 32'h80000000);

        // Backpressure: result must hold while junk products are offered.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_group(32'd100, 32'd1, 32'd1, 32'd1, 32'd1, 0, 32'd104, 32'd104);
        in_valid   = 1'b1;
        in_product = 32'd99;
        repeat (5) @(posedge clk);
        #1;
        probe("bp_in_ready",   {31'd0, if_r1.in_ready},   32'd0);
        probe("bp_beat_count", {24'd0, if_r1.beat_count}, 32'd4);
        probe("bp_out_data",   if_r0.out_data, 32'd104);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        probe("release_out_valid",  {31'd0, if_r1.out_valid},  32'd0);
        probe("release_beat_count", {24'd0, if_r1.beat_count}, 32'd0);
        probe("retained_out_data",  if_r0.out_data, 32'd104);

        // Reset mid-group discards the partial sum.
        send_beat(32'd7, 32'd0);
        send_beat(32'd8, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        probe("midreset_beat_count", {24'd0, if_r1.beat_count}, 32'd0);
        send_group(32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 0, 32'd4, 32'd4);

        // Same as the first group but with random idle gaps between beats.
        send_group(32'd10, 32'd1, 32'd2, 32'd3, 32'd4, 3, 32'd20, 32'd20);
        send_group(32'd10, 32'd1, 32'd2, 32'd3, 32'd4, 3, 32'd20, 32'd20);

        begin
            int t = 0;
            while ((exp_q1.size() > 0 || exp_q0.size() > 0) && t < 50) begin
                @(posedge clk);
                t++;
            end
            #1;
            probe("drain_relu_pending", exp_q1.size(), 32'd0);
            probe("drain_pass_pending", exp_q0.size(), 32'd0);
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
